// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - turns a debounced button level into press/release/click/long/repeat pulses
module button_event_decoder #(
    parameter logic ACTIVE_LEVEL = 1'b1,
    parameter int   CNT_W        = 25,
    parameter int   LONG_CYC     = 19000000,
    parameter int   REPEAT_CYC   = 3800000,
    parameter int   DBL_CYC      = 9500000
) (
    input  logic clk,
    input  logic reset,
    input  logic db_in,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HELD      = 3'd1,
        LONG_HELD = 3'd2,
        WAIT_2ND  = 3'd3,
        HELD2     = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             p;
    logic             p_q;
    logic             prs;
    logic             rel;
    logic             single_next;
    logic             double_next;
    logic             long_next;
    logic             repeat_next;

    assign p   = (db_in == ACTIVE_LEVEL);
    assign prs = p & ~p_q;
    assign rel = ~p & p_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            p_q           <= 1'b0;
            held          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            single_click  <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            p_q           <= p;
            held          <= p;
            press_pulse   <= prs;
            release_pulse <= rel;
            single_click  <= single_next;
            double_click  <= double_next;
            long_press    <= long_next;
            repeat_pulse  <= repeat_next;
        end
    end

    // Edges take priority over timeouts in every state that checks both.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (prs) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end
            end
            HELD: begin
                if (rel) begin
                    state_next = WAIT_2ND;
                    cnt_next   = '0;
                end else if (cnt == LONG_LAST) begin
                    state_next = LONG_HELD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            LONG_HELD: begin
                if (rel) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == REP_LAST) begin
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            WAIT_2ND: begin
                if (prs) begin
                    state_next = HELD2;
                    cnt_next   = '0;
                end else if (cnt == DBL_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HELD2: begin
                if (rel) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        single_next = 1'b0;
        double_next = 1'b0;
        long_next   = 1'b0;
        repeat_next = 1'b0;
        case (state)
            HELD:      long_next   = ~rel & (cnt == LONG_LAST);
            LONG_HELD: repeat_next = ~rel & (cnt == REP_LAST);
            WAIT_2ND: begin
                double_next = prs;
                single_next = ~prs & (cnt == DBL_LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - directed self-checking bench for button_event_decoder
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic reset;
    logic db_in;
    logic db_in_n;
    logic held, press_pulse, release_pulse, single_click, double_click, long_press, repeat_pulse;
    logic held_n, press_n, release_n, single_n, double_n, long_n, repeat_n;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    button_event_decoder #(
        .ACTIVE_LEVEL(1'b1), .CNT_W(8), .LONG_CYC(20), .REPEAT_CYC(5), .DBL_CYC(10)
    ) dut (
        .clk(clk), .reset(reset), .db_in(db_in),
        .held(held), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .single_click(single_click), .double_click(double_click),
        .long_press(long_press), .repeat_pulse(repeat_pulse)
    );

    button_event_decoder #(
        .ACTIVE_LEVEL(1'b0), .CNT_W(8), .LONG_CYC(20), .REPEAT_CYC(5), .DBL_CYC(10)
    ) dut_n (
        .clk(clk), .reset(reset), .db_in(db_in_n),
        .held(held_n), .press_pulse(press_n), .release_pulse(release_n),
        .single_click(single_n), .double_click(double_n),
        .long_press(long_n), .repeat_pulse(repeat_n)
    );

    // Vector order: held, press, release, single, double, long, repeat.
    function automatic logic [6:0] ev(input logic h, input logic pp, input logic rp,
                                      input logic sc, input logic dc, input logic lp,
                                      input logic rt);
        return {h, pp, rp, sc, dc, lp, rt};
    endfunction

    function automatic logic [6:0] obs_main();
        return {held, press_pulse, release_pulse, single_click, double_click, long_press, repeat_pulse};
    endfunction

    function automatic logic [6:0] obs_neg();
        return {held_n, press_n, release_n, single_n, double_n, long_n, repeat_n};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s j=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            chk("gap", k, obs_main(), 7'b0);
        end
    endtask

    initial begin
        reset   = 1'b1;
        db_in   = 1'b0;
        db_in_n = 1'b1;
        tick();
        tick();
        chk("reset_main", 0, obs_main(), 7'b0);
        chk("reset_neg", 0, obs_neg(), 7'b0);
        reset = 1'b0;
        gap(3);

        // Short click
        for (int j = 0; j <= 20; j++) begin
            db_in = (j < 5);
            tick();
            chk("short", j, obs_main(), ev(j < 5, j == 0, j == 5, j == 15, 1'b0, 1'b0, 1'b0));
        end
        gap(3);

        // Double click
        for (int j = 0; j <= 30; j++) begin
            db_in = (j < 5) || (j >= 9 && j < 12);
            tick();
            chk("double", j, obs_main(),
                ev((j < 5) || (j >= 9 && j < 12), j == 0 || j == 9, j == 5 || j == 12,
                   1'b0, j == 9, 1'b0, 1'b0));
        end
        gap(3);

        // Long press with repeat
        for (int j = 0; j <= 55; j++) begin
            db_in = (j < 40);
            tick();
            chk("long", j, obs_main(),
                ev(j < 40, j == 0, j == 40, 1'b0, 1'b0, j == 20,
                   j == 25 || j == 30 || j == 35));
        end
        gap(3);

        // Release on the very edge the long timeout would fire
        for (int j = 0; j <= 35; j++) begin
            db_in = (j < 20);
            tick();
            chk("rel_at_long", j, obs_main(), ev(j < 20, j == 0, j == 20, j == 30, 1'b0, 1'b0, 1'b0));
        end
        gap(3);

        // Second press on the very edge the click window would expire
        for (int j = 0; j <= 30; j++) begin
            db_in = (j < 5) || (j >= 15 && j < 18);
            tick();
            chk("dbl_at_window", j, obs_main(),
                ev((j < 5) || (j >= 15 && j < 18), j == 0 || j == 15, j == 5 || j == 18,
                   1'b0, j == 15, 1'b0, 1'b0));
        end
        gap(3);

        // Reset mid-press; button still down when reset drops
        for (int j = 0; j <= 40; j++) begin
            db_in = (j < 36);
            reset = (j == 12);
            tick();
            if (j < 12)
                chk("rst_pre", j, obs_main(), ev(1'b1, j == 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            else if (j == 12)
                chk("rst_at", j, obs_main(), 7'b0);
            else
                chk("rst_post", j, obs_main(),
                    ev(j < 36, j == 13, j == 36, 1'b0, 1'b0, j == 33, 1'b0));
        end
        reset = 1'b0;
        gap(3);

        // Active-low instance, short click
        for (int j = 0; j <= 20; j++) begin
            db_in_n = !(j < 5);
            tick();
            chk("polarity", j, obs_neg(), ev(j < 5, j == 0, j == 5, j == 15, 1'b0, 1'b0, 1'b0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the button debouncer and consumes its clean, glitch-free level output.
- Turns that level into single-cycle event pulses: press, release, single click, double click, long press, and auto-repeat while a long press is held.
- Feeds the control FSMs and UI logic, so they never need to time button levels themselves.

Parameters:
ACTIVE_LEVEL, 1, logic level of db_in that means "pressed"
CNT_W, 25, width of the shared interval counter; 2^CNT_W must exceed every cycle parameter below
LONG_CYC, 19000000, cycles held before long_press fires (0.5 s at 38 MHz)
REPEAT_CYC, 3800000, cycles between repeat pulses after long_press (100 ms)
DBL_CYC, 9500000, window after a release in which a second press counts as a double click (250 ms)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous reset, active high
db_in  in  1  debounced button level from the debouncer
held  out  1  level, high while the button is sampled as pressed
press_pulse  out  1  one-cycle pulse on each press edge
release_pulse  out  1  one-cycle pulse on each release edge
single_click  out  1  one-cycle pulse: short press with no second press inside the window
double_click  out  1  one-cycle pulse: second press inside DBL_CYC
long_press  out  1  one-cycle pulse: held for LONG_CYC
repeat_pulse  out  1  one-cycle pulse every REPEAT_CYC while held past long_press

Behaviour:
- Clock is clk. Reset is synchronous and active high. One clock domain only.
- Input conditioning:
  - p = (db_in == ACTIVE_LEVEL).
  - p_q is p registered once.
  - prs = p & ~p_q; rel = ~p & p_q.
  - No extra synchroniser is needed; db_in is already synchronous to clk.
- All outputs are registered. Each event pulse is high for exactly one cycle, starting at the clk edge where the edge condition or timeout is evaluated.
- held <= p, so held lags p by one register stage.
- press_pulse <= prs and release_pulse <= rel in every state, independent of the FSM.
- Reset:
  - state = IDLE, cnt = 0, p_q = 0, all outputs 0.
  - If the button is pressed while reset deasserts, press_pulse fires on the first edge after reset deasserts and the FSM enters HELD.
- FSM, 5 states. cnt is checked and then incremented. "edge E+j" means j clocks after the edge E that entered the state.
  - IDLE: on prs -> HELD, cnt <= 0.
  - HELD:
    - rel -> WAIT_2ND, cnt <= 0.
    - Else if cnt == LONG_CYC-1 -> LONG_HELD, long_press = 1, cnt <= 0.
    - Else cnt++.
    - Result: long_press fires at E+LONG_CYC.
  - LONG_HELD:
    - rel -> IDLE; no click is reported.
    - Else if cnt == REPEAT_CYC-1 -> repeat_pulse = 1, cnt <= 0.
    - Else cnt++.
    - Result: repeats at long_press+REPEAT_CYC, +2*REPEAT_CYC, and so on.
  - WAIT_2ND:
    - prs -> HELD2, double_click = 1.
    - Else if cnt == DBL_CYC-1 -> IDLE, single_click = 1.
    - Else cnt++.
    - Result: single_click fires at release+DBL_CYC.
  - HELD2: rel -> IDLE. No long or repeat detection during the second press. cnt is idle.
- Simultaneous events:
  - HELD, rel on the same edge as cnt == LONG_CYC-1: release wins; treated as a short press -> WAIT_2ND.
  - WAIT_2ND, prs on the same edge as cnt == DBL_CYC-1: press wins; double_click fires.
- Mutual exclusion:
  - At most one of single_click, double_click, long_press, repeat_pulse is high in any cycle.
  - press_pulse may coincide with double_click.
  - release_pulse never coincides with long_press or repeat_pulse.
- Reset mid-operation: on any edge with reset = 1, the reset values above apply immediately and no pending click is emitted.
- Counter: unsigned CNT_W bits, never wraps in normal operation. Cycle parameters must be >= 2; illegal values are not guarded.

Test Plan:
Bench overrides: LONG_CYC=20, REPEAT_CYC=5, DBL_CYC=10, ACTIVE_LEVEL=1.

1. Short click: db_in high for 5 cycles, then low -> press_pulse at edge P, release_pulse at P+5, single_click at P+15, no other pulses; held high for 5 cycles.
2. Double click: press 5 cycles, low 4 cycles, press 3 cycles -> double_click together with the second press_pulse; no single_click; return to IDLE after the second release_pulse.
3. Long press with repeat: db_in held 40 cycles -> long_press at P+20; repeat_pulse at P+25, P+30, P+35; release -> release_pulse only, no click.
4. Boundaries:
   - Release exactly at P+20 -> no long_press; single_click 10 cycles later.
   - Second press exactly at release+10 -> double_click, not single_click.
5. Reset mid-operation:
   - Assert reset for 1 cycle at P+12 while held -> all outputs 0.
   - Then, with db_in still high, press_pulse on the first edge after reset drops and long_press 20 cycles later.
6. Polarity: ACTIVE_LEVEL=0, db_in pulsed low for 5 cycles -> same pulse timing as scenario 1.
